// File: rtl/spike_dispatch_scheduler.sv
// Two-requester spike scheduler feeding the synapse array: per-requester FIFOs, one issue, then an enable-gated holdoff.
// Optional build macro SPK_SCHED_REC_PRIO_EN: strict recurrent priority instead of round-robin.
module spike_dispatch_scheduler #(
  parameter int NUM_AXONS      = 64,
  parameter int NUM_NEURONS    = 64,
  parameter int AXON_ID_WIDTH  = $clog2(NUM_AXONS),
  parameter int FIFO_DEPTH     = 8,
  parameter int HOLDOFF_CYCLES = 2*NUM_NEURONS+2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ext_valid,
  input  logic [AXON_ID_WIDTH-1:0] ext_axon_id,
  output logic                     ext_ready,
  input  logic                     rec_valid,
  input  logic [AXON_ID_WIDTH-1:0] rec_axon_id,
  output logic                     rec_ready,
  input  logic                     sa_enable,
  input  logic                     flush,
  output logic                     sa_spike_valid,
  output logic [AXON_ID_WIDTH-1:0] sa_spike_axon_id,
  output logic                     sched_idle,
  output logic [CNT_WIDTH-1:0]     dispatch_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W  = PTR_W - 1;
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                   state;
  logic [HOLD_W-1:0]        hold_cnt;

  logic [AXON_ID_WIDTH-1:0] ext_mem [FIFO_DEPTH];
  logic [AXON_ID_WIDTH-1:0] rec_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         ext_wr_ptr, ext_rd_ptr;
  logic [PTR_W-1:0]         rec_wr_ptr, rec_rd_ptr;

  logic                     ext_empty, ext_full, rec_empty, rec_full;
  logic                     ext_push, rec_push, ext_pop, rec_pop;
  logic                     issue, grant_rec;
  logic [AXON_ID_WIDTH-1:0] pop_id;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign ext_empty = (ext_wr_ptr == ext_rd_ptr);
  assign rec_empty = (rec_wr_ptr == rec_rd_ptr);
  assign ext_full  = (ext_wr_ptr[PTR_W-1] != ext_rd_ptr[PTR_W-1]) &&
                     (ext_wr_ptr[IDX_W-1:0] == ext_rd_ptr[IDX_W-1:0]);
  assign rec_full  = (rec_wr_ptr[PTR_W-1] != rec_rd_ptr[PTR_W-1]) &&
                     (rec_wr_ptr[IDX_W-1:0] == rec_rd_ptr[IDX_W-1:0]);

  assign ext_ready = !ext_full;
  assign rec_ready = !rec_full;
  assign ext_push  = ext_valid && !ext_full && !flush;
  assign rec_push  = rec_valid && !rec_full && !flush;

  assign issue = (state == S_IDLE) && sa_enable && (!ext_empty || !rec_empty);

`ifdef SPK_SCHED_REC_PRIO_EN
  assign grant_rec = !rec_empty;
`else
  logic last_rec;

  // Tie goes to whichever requester was not served last.
  assign grant_rec = !rec_empty && (ext_empty || !last_rec);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_rec <= 1'b1;
    end else if (issue) begin
      last_rec <= grant_rec;
    end
  end
`endif

  assign ext_pop = issue && !grant_rec;
  assign rec_pop = issue && grant_rec;
  assign pop_id  = grant_rec ? rec_mem[rec_rd_ptr[IDX_W-1:0]]
                             : ext_mem[ext_rd_ptr[IDX_W-1:0]];

  assign sched_idle = (state == S_IDLE) && ext_empty && rec_empty;

  // FIFO storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (ext_push) ext_mem[ext_wr_ptr[IDX_W-1:0]] <= ext_axon_id;
    if (rec_push) rec_mem[rec_wr_ptr[IDX_W-1:0]] <= rec_axon_id;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ext_wr_ptr <= '0;
      ext_rd_ptr <= '0;
      rec_wr_ptr <= '0;
      rec_rd_ptr <= '0;
    end else begin
      if (ext_push) ext_wr_ptr <= ext_wr_ptr + PTR_W'(1);
      if (ext_pop)  ext_rd_ptr <= ext_rd_ptr + PTR_W'(1);
      if (rec_push) rec_wr_ptr <= rec_wr_ptr + PTR_W'(1);
      if (rec_pop)  rec_rd_ptr <= rec_rd_ptr + PTR_W'(1);
    end
  end

  // Issue / holdoff state machine; the holdoff only advances while the array is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      hold_cnt         <= '0;
      sa_spike_valid   <= 1'b0;
      sa_spike_axon_id <= '0;
      dispatch_count   <= '0;
    end else begin
      sa_spike_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue) begin
            sa_spike_valid   <= 1'b1;
            sa_spike_axon_id <= pop_id;
            dispatch_count   <= dispatch_count + CNT_WIDTH'(1);
            hold_cnt         <= HOLD_LOAD;
            state            <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (sa_enable) begin
            if (hold_cnt == '0) begin
              state <= S_IDLE;
            end else begin
              hold_cnt <= hold_cnt - HOLD_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_dispatch_scheduler.sv
// Scoreboard bench for spike_dispatch_scheduler: stimulus queues expected issues, a negedge monitor checks them.
module tb_spike_dispatch_scheduler;

  localparam int AW   = 6;
  localparam int H    = 130;   // 2*64+2
  localparam int GAP  = 131;   // H+1

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ext_valid = 1'b0;
  logic [AW-1:0] ext_axon_id = '0;
  logic          ext_ready;
  logic          rec_valid = 1'b0;
  logic [AW-1:0] rec_axon_id = '0;
  logic          rec_ready;
  logic          sa_enable = 1'b0;
  logic          flush = 1'b0;
  logic          sa_spike_valid;
  logic [AW-1:0] sa_spike_axon_id;
  logic          sched_idle;
  logic [15:0]   dispatch_count;

  spike_dispatch_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .ext_valid        (ext_valid),
    .ext_axon_id      (ext_axon_id),
    .ext_ready        (ext_ready),
    .rec_valid        (rec_valid),
    .rec_axon_id      (rec_axon_id),
    .rec_ready        (rec_ready),
    .sa_enable        (sa_enable),
    .flush            (flush),
    .sa_spike_valid   (sa_spike_valid),
    .sa_spike_axon_id (sa_spike_axon_id),
    .sched_idle       (sched_idle),
    .dispatch_count   (dispatch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int cnt;
    int gap;   // 0 = spacing not checked
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input int id, input int cnt, input int gap);
    exp_t e;
    e.id = id; e.cnt = cnt; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, int'(sa_spike_valid), 0);
    chk({tag, "_id"},    int'(sa_spike_axon_id), 0);
    chk({tag, "_count"}, int'(dispatch_count), 0);
    chk({tag, "_idle"},  int'(sched_idle), 1);
    chk({tag, "_ext_ready"}, int'(ext_ready), 1);
    chk({tag, "_rec_ready"}, int'(rec_ready), 1);
  endtask

  // Monitor: every issue pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sa_spike_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue_id", int'(sa_spike_axon_id), -1);
        end else begin
          e = exp_q.pop_front();
          chk("issue_id", int'(sa_spike_axon_id), e.id);
          chk("issue_count", int'(dispatch_count), e.cnt);
          if (e.gap != 0) chk("issue_gap", cyc - last_cyc, e.gap);
        end
        last_cyc = cyc;
      end
    end
  end

  initial begin
    // Reset values
    rst = 1'b1;
    tick(); tick();
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Single external spike: two-cycle latency, one-cycle pulse, idle after holdoff
    sa_enable = 1'b1;
    expect_issue(5, 1, 0);
    ext_valid = 1'b1; ext_axon_id = 6'd5;
    tick();
    ext_valid = 1'b0;
    tick();
    chk("single_pulse_hi", int'(sa_spike_valid), 1);
    tick();
    chk("single_pulse_lo", int'(sa_spike_valid), 0);
    repeat (H - 2) tick();
    chk("single_busy", int'(sched_idle), 0);
    tick();
    chk("single_idle", int'(sched_idle), 1);
    chk("single_count", int'(dispatch_count), 1);

    // Arbitration with both FIFOs loaded before the first issue
    sa_enable = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ext_valid = 1'b1; ext_axon_id = AW'(1 + i);
      rec_valid = 1'b1; rec_axon_id = AW'(10 + i);
      tick();
    end
    ext_valid = 1'b0; rec_valid = 1'b0;
`ifdef SPK_SCHED_REC_PRIO_EN
    expect_issue(10, 1, 0);  expect_issue(11, 2, GAP); expect_issue(12, 3, GAP);
    expect_issue(1, 4, GAP); expect_issue(2, 5, GAP);  expect_issue(3, 6, GAP);
`else
    expect_issue(1, 1, 0);   expect_issue(10, 2, GAP); expect_issue(2, 3, GAP);
    expect_issue(11, 4, GAP); expect_issue(3, 5, GAP); expect_issue(12, 6, GAP);
`endif
    sa_enable = 1'b1;
    repeat (6 * GAP + 5) tick();
    chk("arb_drained", exp_q.size(), 0);
    chk("arb_idle", int'(sched_idle), 1);

    // Fill the external FIFO with no grant; the ninth push is refused
    sa_enable = 1'b0;
    ext_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ext_axon_id = AW'(20 + i);
      tick();
    end
    chk("full_ext_ready", int'(ext_ready), 0);
    chk("full_rec_ready", int'(rec_ready), 1);
    ext_axon_id = 6'd28;
    tick();
    chk("full_ext_ready_hold", int'(ext_ready), 0);
    chk("full_no_issue", int'(dispatch_count), 6);
    ext_valid = 1'b0;
    for (int i = 0; i < 8; i++) expect_issue(20 + i, 7 + i, (i == 0) ? 0 : GAP);
    sa_enable = 1'b1;
    repeat (8 * GAP + 5) tick();
    chk("full_drained", exp_q.size(), 0);
    chk("full_idle", int'(sched_idle), 1);

    // Dropping sa_enable for 20 cycles in WAIT stretches the spacing by 20
    sa_enable = 1'b0;
    ext_valid = 1'b1;
    ext_axon_id = 6'd30; tick();
    ext_axon_id = 6'd31; tick();
    ext_valid = 1'b0;
    expect_issue(30, 15, 0);
    expect_issue(31, 16, GAP + 20);
    sa_enable = 1'b1;
    tick();
    repeat (10) tick();
    sa_enable = 1'b0;
    repeat (20) tick();
    sa_enable = 1'b1;
    repeat (260) tick();
    chk("stall_drained", exp_q.size(), 0);
    chk("stall_idle", int'(sched_idle), 1);

    // Flush during WAIT with a concurrent push
    expect_issue(40, 17, 0);
    ext_valid = 1'b1;
    ext_axon_id = 6'd40; tick();
    for (int i = 0; i < 4; i++) begin
      ext_axon_id = AW'(41 + i);
      tick();
    end
    flush = 1'b1; ext_axon_id = 6'd45;
    tick();
    flush = 1'b0; ext_valid = 1'b0;
    chk("flush_still_wait", int'(sched_idle), 0);
    chk("flush_ext_ready", int'(ext_ready), 1);
    repeat (130) tick();
    chk("flush_idle", int'(sched_idle), 1);
    repeat (150) tick();
    chk("flush_no_issue", int'(dispatch_count), 17);
    chk("flush_drained", exp_q.size(), 0);

    // Reset in WAIT with a queued entry drops everything
    expect_issue(50, 18, 0);
    ext_valid = 1'b1;
    ext_axon_id = 6'd50; tick();
    ext_axon_id = 6'd51; tick();
    ext_valid = 1'b0;
    repeat (10) tick();
    chk("prereset_busy", int'(sched_idle), 0);
    rst = 1'b1;
    tick();
    chk_reset_outputs("midreset");
    rst = 1'b0;
    repeat (300) tick();
    chk("postreset_idle", int'(sched_idle), 1);
    chk("postreset_count", int'(dispatch_count), 0);
    expect_issue(52, 1, 0);
    ext_valid = 1'b1; ext_axon_id = 6'd52;
    tick();
    ext_valid = 1'b0;
    repeat (3) tick();
    chk("postreset_new_count", int'(dispatch_count), 1);
    chk("postreset_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
